delay_seq_ctrl: RTL and testbench

- Sequencer for the 7-slot, 7-bit programmable register delay datapath.
- Drives the datapath's write-slot select (sel_reg) and read-slot select (sel_mux) so that a stream of input samples is written round-robin into slots 1..7.
- The sample written N accepted samples earlier (N = programmed delay, 1..7) is presented on the datapath output.
- Handles fill-up after reset or reconfiguration, strobes each valid delayed sample, and flushes history whenever the delay changes.

---
 rtl/delay_seq_ctrl.sv | 122 ++++++++++++
 tb/tb_delay_seq_ctrl.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/delay_seq_ctrl.sv
// Sequencer for the 7-slot programmable register delay datapath: round-robin write
// slot select, delayed read slot select and output strobe. Optional macro: DELAY_SEQ_DROP_CNT_EN.
module delay_seq_ctrl #(
  parameter int unsigned R             = 8,
  parameter int unsigned A             = 3,
  parameter int unsigned DEFAULT_DELAY = 3
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         enable,
  input  logic         cfg_load,
  input  logic [A-1:0] cfg_delay,
  input  logic         in_valid,
  output logic         in_ready,
  output logic [A-1:0] sel_reg,
  output logic [A-1:0] sel_mux,
  output logic         out_strobe,
  output logic [A-1:0] fill_cnt,
  output logic [A-1:0] delay_q,
  output logic [7:0]   drop_cnt
);

  localparam logic [A-1:0] SLOT_FIRST = A'(1);
  localparam logic [A-1:0] SLOT_LAST  = A'(R - 1);
  localparam logic [A-1:0] DELAY_RST  = A'(DEFAULT_DELAY);
  localparam logic [A:0]   R_W        = (A + 1)'(R);
  localparam logic [A:0]   RM1_W      = (A + 1)'(R - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_FILL,
    S_RUN,
    S_FLUSH
  } state_t;

  state_t       state_q, state_d;
  logic [A-1:0] wp, lw;
  logic         in_fire;
  logic [A:0]   fill_inc;
  logic         fill_reached;
  logic [A:0]   rd_sum;
  logic [A-1:0] rd_slot;

  always_comb begin
    in_ready     = ((state_q == S_FILL) || (state_q == S_RUN)) && !cfg_load;
    in_fire      = in_valid && in_ready;
    fill_inc     = {1'b0, fill_cnt} + (A + 1)'(1);
    fill_reached = fill_inc >= {1'b0, delay_q};
    sel_reg      = in_fire ? wp : '0;
  end

  // Read slot is lw-(delay_q-1) wrapped into 1..R-1; biased by R to stay unsigned.
  always_comb begin
    rd_sum  = {1'b0, lw} + R_W - {1'b0, delay_q};
    rd_slot = (rd_sum >= R_W) ? A'(rd_sum - RM1_W) : A'(rd_sum);
    sel_mux = (state_q == S_RUN) ? rd_slot : '0;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (cfg_load)                state_d = S_FLUSH;
        else if (enable)             state_d = (fill_cnt < delay_q) ? S_FILL : S_RUN;
      end
      S_FILL: begin
        if (cfg_load)                state_d = S_FLUSH;
        else if (!enable)            state_d = S_IDLE;
        else if (in_fire && fill_reached) state_d = S_RUN;
      end
      S_RUN: begin
        if (cfg_load)                state_d = S_FLUSH;
        else if (!enable)            state_d = S_IDLE;
      end
      S_FLUSH: begin
        if (cfg_load)                state_d = S_FLUSH;
        else                         state_d = enable ? S_FILL : S_IDLE;
      end
      default:                       state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Flush work is done on the cfg_load edge itself, so the FLUSH cycle already sees clean state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wp         <= SLOT_FIRST;
      lw         <= SLOT_LAST;
      fill_cnt   <= '0;
      delay_q    <= DELAY_RST;
      out_strobe <= 1'b0;
    end else if (cfg_load) begin
      wp         <= SLOT_FIRST;
      lw         <= SLOT_LAST;
      fill_cnt   <= '0;
      delay_q    <= (cfg_delay == '0) ? SLOT_FIRST : cfg_delay;
      out_strobe <= 1'b0;
    end else begin
      out_strobe <= in_fire && fill_reached;
      if (in_fire) begin
        lw       <= wp;
        wp       <= (wp == SLOT_LAST) ? SLOT_FIRST : wp + SLOT_FIRST;
        fill_cnt <= (fill_cnt == SLOT_LAST) ? fill_cnt : fill_cnt + SLOT_FIRST;
      end
    end
  end

`ifdef DELAY_SEQ_DROP_CNT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                          drop_cnt <= '0;
    else if (cfg_load)                                drop_cnt <= '0;
    else if (in_valid && !in_ready && drop_cnt != '1) drop_cnt <= drop_cnt + 8'd1;
  end
`else
  assign drop_cnt = '0;
`endif

endmodule

// File: tb/tb_delay_seq_ctrl.sv
// Self-checking bench for delay_seq_ctrl: sample-count model plus an emulated slot datapath.
module tb_delay_seq_ctrl;

  logic       clk = 1'b0;
  logic       rst, enable, cfg_load, in_valid;
  logic [2:0] cfg_delay;
  logic       in_ready, out_strobe;
  logic [2:0] sel_reg, sel_mux, fill_cnt, delay_q;
  logic [7:0] drop_cnt;
  int         din;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  delay_seq_ctrl #(.R(8), .A(3), .DEFAULT_DELAY(3)) dut (
    .clk(clk), .rst(rst), .enable(enable), .cfg_load(cfg_load), .cfg_delay(cfg_delay),
    .in_valid(in_valid), .in_ready(in_ready), .sel_reg(sel_reg), .sel_mux(sel_mux),
    .out_strobe(out_strobe), .fill_cnt(fill_cnt), .delay_q(delay_q), .drop_cnt(drop_cnt)
  );

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s t=%0t actual=%0d expected=%0d", name, $time, act, exp);
    end
  endtask

  // Model: live = enabled and not loading at the last edge; acc = samples accepted since flush.
  bit m_live   = 1'b0;
  bit m_strobe = 1'b0;
  bit p_fire;
  int m_acc    = 0;
  int m_delay  = 3;
  int m_drop   = 0;
  int hist[$];
  int mem[8];

  initial forever begin
    @(posedge clk or posedge rst);
    if (rst) begin
      m_live = 1'b0; m_strobe = 1'b0; m_acc = 0; m_delay = 3; m_drop = 0;
      hist.delete();
    end else begin
      p_fire   = m_live && !cfg_load && in_valid;
      m_strobe = p_fire && (m_acc + 1 >= m_delay);
`ifdef DELAY_SEQ_DROP_CNT_EN
      if (cfg_load) m_drop = 0;
      else if (in_valid && !(m_live && !cfg_load) && m_drop < 255) m_drop++;
`endif
      if (cfg_load) begin
        m_delay = (cfg_delay == 3'd0) ? 1 : int'(cfg_delay);
        m_acc   = 0;
        hist.delete();
      end else if (p_fire) begin
        hist.push_back(din);
        m_acc++;
      end
      m_live = enable && !cfg_load;
    end
  end

  int e_rdy, e_sreg, e_smux;
  initial forever begin
    @(negedge clk);
    e_rdy  = (m_live && !cfg_load) ? 1 : 0;
    e_sreg = (e_rdy == 1 && in_valid) ? (m_acc % 7) + 1 : 0;
    e_smux = (m_live && m_acc >= m_delay) ? ((m_acc - m_delay) % 7) + 1 : 0;
    chk("in_ready",   int'(in_ready),   e_rdy);
    chk("sel_reg",    int'(sel_reg),    e_sreg);
    chk("sel_mux",    int'(sel_mux),    e_smux);
    chk("out_strobe", int'(out_strobe), int'(m_strobe));
    chk("fill_cnt",   int'(fill_cnt),   (m_acc > 7) ? 7 : m_acc);
    chk("delay_q",    int'(delay_q),    m_delay);
    chk("drop_cnt",   int'(drop_cnt),   m_drop);
    if (m_strobe && e_smux != 0)
      chk("data", mem[sel_mux], hist[m_acc - m_delay]);
    if (sel_reg != 3'd0) mem[sel_reg] = din;
  end

  task automatic drive(input bit en, input bit ld, input int dly, input bit v, input int d);
    @(posedge clk);
    #1;
    enable = en; cfg_load = ld; cfg_delay = 3'(dly); in_valid = v; din = d;
    #2;
  endtask

  initial begin
    rst = 1'b1; enable = 1'b0; cfg_load = 1'b0; cfg_delay = 3'd0; in_valid = 1'b0; din = 0;
    @(posedge clk); @(posedge clk); #3;
    chk("rst_sel_reg", int'(sel_reg), 0);
    chk("rst_sel_mux", int'(sel_mux), 0);
    chk("rst_in_ready", int'(in_ready), 0);
    chk("rst_fill", int'(fill_cnt), 0);
    chk("rst_delay", int'(delay_q), 3);
    chk("rst_strobe", int'(out_strobe), 0);
    chk("rst_drop", int'(drop_cnt), 0);
    @(posedge clk); #1; rst = 1'b0;

    // delay 3, samples 10..13
    drive(1, 0, 0, 0, 0);  chk("t1_idle_ready", int'(in_ready), 0);
    drive(1, 0, 0, 1, 10); chk("t1_ready", int'(in_ready), 1); chk("t1_w1", int'(sel_reg), 1);
    drive(1, 0, 0, 1, 11); chk("t1_w2", int'(sel_reg), 2);
    drive(1, 0, 0, 1, 12); chk("t1_w3", int'(sel_reg), 3); chk("t1_nostb", int'(out_strobe), 0);
    drive(1, 0, 0, 1, 13); chk("t1_w4", int'(sel_reg), 4);
    chk("t1_stb1", int'(out_strobe), 1); chk("t1_rd1", int'(sel_mux), 1);
    drive(1, 0, 0, 0, 0);  chk("t1_stb2", int'(out_strobe), 1); chk("t1_rd2", int'(sel_mux), 2);
    chk("t1_fill", int'(fill_cnt), 4);

    // delay 7, nine samples wrapping the slots
    drive(1, 1, 7, 0, 0);  chk("t2_ld_ready", int'(in_ready), 0);
    drive(1, 0, 0, 0, 0);  chk("t2_delay", int'(delay_q), 7); chk("t2_fill0", int'(fill_cnt), 0);
    chk("t2_flush_ready", int'(in_ready), 0);
    for (int i = 0; i < 9; i++) begin
      drive(1, 0, 0, 1, 20 + i);
      chk("t2_wr", int'(sel_reg), (i % 7) + 1);
      if (i < 7)  chk("t2_nostb", int'(out_strobe), 0);
      if (i == 7) begin chk("t2_stb", int'(out_strobe), 1); chk("t2_rd1", int'(sel_mux), 1); end
      if (i == 8) chk("t2_rd2", int'(sel_mux), 2);
    end
    drive(1, 0, 0, 0, 0);  chk("t2_rd3", int'(sel_mux), 3); chk("t2_stb3", int'(out_strobe), 1);

    // cfg_load beats a simultaneous sample
    drive(1, 1, 2, 1, 99); chk("t3_ready", int'(in_ready), 0); chk("t3_sreg", int'(sel_reg), 0);
    drive(1, 0, 0, 0, 0);  chk("t3_fill0", int'(fill_cnt), 0); chk("t3_delay", int'(delay_q), 2);
    chk("t3_flush_ready", int'(in_ready), 0);
    drive(1, 0, 0, 1, 30); chk("t3_w1", int'(sel_reg), 1);
    drive(1, 0, 0, 1, 31); chk("t3_w2", int'(sel_reg), 2); chk("t3_nostb", int'(out_strobe), 0);
    drive(1, 0, 0, 0, 0);  chk("t3_stb", int'(out_strobe), 1); chk("t3_rd", int'(sel_mux), 1);

    // delay 0 clamps to 1
    drive(1, 1, 0, 0, 0);
    drive(1, 0, 0, 0, 0);  chk("t4_delay", int'(delay_q), 1);
    drive(1, 0, 0, 1, 40); chk("t4_w1", int'(sel_reg), 1);
    drive(1, 0, 0, 1, 41); chk("t4_stb1", int'(out_strobe), 1); chk("t4_rd1", int'(sel_mux), 1);
    drive(1, 0, 0, 0, 0);  chk("t4_stb2", int'(out_strobe), 1); chk("t4_rd2", int'(sel_mux), 2);

    // enable dropped in RUN with fill 5, delay 4
    drive(1, 1, 4, 0, 0);
    drive(1, 0, 0, 0, 0);
    for (int i = 0; i < 5; i++) drive(1, 0, 0, 1, 50 + i);
    drive(0, 0, 0, 0, 0);
    drive(0, 0, 0, 1, 77); chk("t5_ready", int'(in_ready), 0); chk("t5_rd", int'(sel_mux), 0);
    chk("t5_sreg", int'(sel_reg), 0); chk("t5_fill", int'(fill_cnt), 5);
    drive(1, 0, 0, 0, 0);  chk("t5_idle_ready", int'(in_ready), 0);
    drive(1, 0, 0, 1, 55); chk("t5_ready2", int'(in_ready), 1); chk("t5_w6", int'(sel_reg), 6);
    chk("t5_rd_run", int'(sel_mux), 2);
    drive(1, 0, 0, 0, 0);  chk("t5_stb", int'(out_strobe), 1); chk("t5_rd2", int'(sel_mux), 3);

    // sweep every delay with a gapped sample stream
    for (int d = 1; d <= 7; d++) begin
      drive(1, 1, d, 0, 0);
      for (int i = 0; i < 14; i++) drive(1, 0, 0, (i % 3) != 2, 60 + 16 * d + i);
    end

    // refused samples while disabled
    drive(0, 0, 0, 0, 0);
    for (int i = 0; i < 300; i++) drive(0, 0, 0, 1, 0);
`ifdef DELAY_SEQ_DROP_CNT_EN
    chk("t6_drop_sat", int'(drop_cnt), 255);
`else
    chk("t6_drop_tied", int'(drop_cnt), 0);
`endif
    drive(0, 1, 3, 1, 0);
    drive(0, 0, 0, 0, 0);  chk("t6_drop_clr", int'(drop_cnt), 0);

    // reset in the middle of a write
    drive(1, 0, 0, 0, 0);
    drive(1, 0, 0, 1, 5);  chk("t7_w1", int'(sel_reg), 1);
    rst = 1'b1;
    #1;
    chk("t7_rst_sreg", int'(sel_reg), 0); chk("t7_rst_fill", int'(fill_cnt), 0);
    chk("t7_rst_ready", int'(in_ready), 0);
    @(posedge clk); #1; rst = 1'b0; in_valid = 1'b0;
    drive(1, 0, 0, 1, 6);  chk("t7_w1_again", int'(sel_reg), 1);
    drive(1, 0, 0, 0, 0);  chk("t7_fill", int'(fill_cnt), 1);
    drive(0, 0, 0, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
